// File: rtl/kyo_anim_pkg.sv
// Shared types and defaults for the fighter-sprite animation controller.
package kyo_anim_pkg;

  typedef enum logic [1:0] {IDLE, WALK_FWD, WALK_BACK, ATTACK} anim_state_t;

  localparam logic [1:0] MV_IDLE = 2'b00;
  localparam logic [1:0] MV_FWD  = 2'b01;
  localparam logic [1:0] MV_BACK = 2'b10;

  localparam int SPR_W_DEF  = 64;
  localparam int SPR_H_DEF  = 128;
  localparam int FRAMES_DEF = 4;
  localparam int HOLD_DEF   = 6;

  // Code 11 has no meaning and falls back to standing still.
  function automatic anim_state_t move_state(input logic [1:0] mv);
    case (mv)
      MV_FWD:  return WALK_FWD;
      MV_BACK: return WALK_BACK;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/kyo_anim_seq.sv
// Animation state machine: picks the strip, steps frames on vblank ticks and
// runs the one-shot attack handshake.
module kyo_anim_seq
  import kyo_anim_pkg::*;
#(
  parameter int FRAMES = FRAMES_DEF,
  parameter int HOLD   = HOLD_DEF
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      frame_start,
  input  logic [1:0]                move_req,
  input  logic                      attack_req,
  output logic                      attack_busy,
  output logic [$clog2(FRAMES)-1:0] frame_idx
);

  localparam int FRAME_W = $clog2(FRAMES);
  localparam int HOLD_W  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD - 1);

  anim_state_t        state, state_nx, mv_state;
  logic [FRAME_W-1:0] frame_nx;
  logic [HOLD_W-1:0]  hold, hold_nx;
  logic               pending, pending_nx, busy_nx;

  function automatic logic [FRAME_W-1:0] start_frame(input anim_state_t s);
    return (s == WALK_BACK) ? FRAME_LAST : '0;
  endfunction

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      frame_idx   <= '0;
      hold        <= '0;
      pending     <= 1'b0;
      attack_busy <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_idx   <= frame_nx;
      hold        <= hold_nx;
      pending     <= pending_nx;
      attack_busy <= busy_nx;
    end
  end

  // Everything except request latching waits for vblank so a frame never tears.
  always_comb begin
    state_nx   = state;
    frame_nx   = frame_idx;
    hold_nx    = hold;
    busy_nx    = attack_busy;
    pending_nx = pending | (attack_req & ~attack_busy);
    mv_state   = move_state(move_req);
    if (frame_start) begin
      if (state == ATTACK && hold == HOLD_LAST && frame_idx == FRAME_LAST) begin
        state_nx = mv_state;
        frame_nx = start_frame(mv_state);
        hold_nx  = '0;
        busy_nx  = 1'b0;
      end else if (state != ATTACK && pending) begin
        state_nx   = ATTACK;
        frame_nx   = '0;
        hold_nx    = '0;
        busy_nx    = 1'b1;
        pending_nx = 1'b0;
      end else if (state != ATTACK && mv_state != state) begin
        state_nx = mv_state;
        frame_nx = start_frame(mv_state);
        hold_nx  = '0;
      end else if (hold == HOLD_LAST) begin
        hold_nx = '0;
        case (state)
          WALK_FWD, ATTACK: frame_nx = frame_idx + 1'b1;
          WALK_BACK:        frame_nx = frame_idx - 1'b1;
          default:          frame_nx = '0;
        endcase
      end else begin
        hold_nx = hold + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kyo_anim_ctrl.sv
// Fighter sprite controller: animation sequencing plus registered sprite-ROM
// address and in-box flag for the current draw coordinate.
module kyo_anim_ctrl
  import kyo_anim_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int FRAMES = FRAMES_DEF,
  parameter int HOLD   = HOLD_DEF,
  parameter int ADDR_W = 15
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      frame_start,
  input  logic [9:0]                draw_x,
  input  logic [9:0]                draw_y,
  input  logic [9:0]                pos_x,
  input  logic [9:0]                pos_y,
  input  logic [1:0]                move_req,
  input  logic                      facing_left,
  input  logic                      attack_req,
  output logic                      attack_busy,
  output logic [$clog2(FRAMES)-1:0] frame_idx,
  output logic [ADDR_W-1:0]         rom_address,
  output logic                      sprite_on
);

  localparam int X_W = $clog2(SPR_W);
  localparam int Y_W = $clog2(SPR_H);
  localparam logic [9:0]     SPR_W_L  = 10'(SPR_W);
  localparam logic [9:0]     SPR_H_L  = 10'(SPR_H);
  localparam logic [X_W-1:0] COL_LAST = X_W'(SPR_W - 1);

  logic [9:0]        dx_p0, dy_p0;
  logic              on_p0, on_p1;
  logic [X_W-1:0]    col_p0;
  logic [ADDR_W-1:0] addr_p0, addr_p1;

  kyo_anim_seq #(
    .FRAMES (FRAMES),
    .HOLD   (HOLD)
  ) u_seq (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .move_req    (move_req),
    .attack_req  (attack_req),
    .attack_busy (attack_busy),
    .frame_idx   (frame_idx)
  );

  // Offsets wrap mod 1024, so a pixel left of or above the sprite lands far out of range.
  assign dx_p0   = draw_x - pos_x;
  assign dy_p0   = draw_y - pos_y;
  assign on_p0   = (dx_p0 < SPR_W_L) && (dy_p0 < SPR_H_L);
  assign col_p0  = facing_left ? (COL_LAST - dx_p0[X_W-1:0]) : dx_p0[X_W-1:0];
  assign addr_p0 = on_p0 ? {frame_idx, dy_p0[Y_W-1:0], col_p0} : '0;

  // Stage p1: address and in-box flag presented to the sprite ROM
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_p1 <= '0;
      on_p1   <= 1'b0;
    end else begin
      addr_p1 <= addr_p0;
      on_p1   <= on_p0;
    end
  end

  assign rom_address = addr_p1;
  assign sprite_on   = on_p1;

endmodule

// File: doc/kyo_anim_ctrl.md
# kyo_anim_ctrl

Animation sequencer and address generator for one fighter sprite. It decides which animation frame is shown, advances frames on vertical-blank ticks, runs one-shot attack animations, and turns the current draw coordinate into a registered sprite-ROM address and an in-box flag. The outputs feed the sprite ROM/palette datapath, and the in-box flag goes to the layer mux.

## Interface
Parameters:
- SPR_W, 64: sprite width in pixels; power of two.
- SPR_H, 128: sprite height in pixels; power of two.
- FRAMES, 4: frames per animation strip; power of two.
- HOLD, 6: frame_start pulses each animation frame is displayed.
- ADDR_W, 15: ROM address width; equals log2(FRAMES·SPR_W·SPR_H).

Ports:
- vga_clk, in, 1: pixel clock; all state on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- frame_start, in, 1: one-cycle pulse at start of vertical blank.
- draw_x, in, 10: current pixel column.
- draw_y, in, 10: current pixel row.
- pos_x, in, 10: sprite top-left column.
- pos_y, in, 10: sprite top-left row.
- move_req, in, 2: 00 idle, 01 forward, 10 backward, 11 treated as idle.
- facing_left, in, 1: mirror sprite horizontally.
- attack_req, in, 1: single-cycle request for a one-shot attack animation.
- attack_busy, out, 1: attack animation in progress.
- frame_idx, out, log2(FRAMES): frame currently displayed.
- rom_address, out, ADDR_W: sprite ROM address.
- sprite_on, out, 1: current pixel lies inside the sprite box.

## Operation
- Reset: state IDLE; frame_idx, hold counter, attack_pending, attack_busy, rom_address and sprite_on all 0.
- attack_req is latched into attack_pending on any cycle. It is ignored while attack_busy=1.
- All state, frame and mode changes happen only on cycles where frame_start=1. No change is allowed mid-frame (no tearing). facing_left is the one exception and is used live.
- States:
  - IDLE: frame_idx held at 0.
  - WALK_FWD: frame_idx counts 0,1,…,FRAMES-1, then wraps to 0.
  - WALK_BACK: frame_idx counts FRAMES-1 down to 0, then wraps to FRAMES-1.
  - ATTACK: plays 0…FRAMES-1 once.
- Transitions, evaluated only at frame_start:
  - From any non-ATTACK state: if attack_pending, go to ATTACK with frame_idx=0 and hold=0, clear attack_pending, set attack_busy. Attack wins over a simultaneous move_req change.
  - Otherwise the next state follows move_req.
  - On a change of state, frame_idx is loaded with the new state's start frame (0, or FRAMES-1 for WALK_BACK) and hold=0.
- Frame advance: in the same state, hold increments each frame_start. When hold==HOLD-1, hold→0 and frame_idx steps.
- ATTACK completes at the frame_start where hold==HOLD-1 and frame_idx==FRAMES-1:
  - attack_busy clears and the state becomes move_req's state.
  - move_req is ignored for the whole attack.
- Address generation:
  - dx = draw_x − pos_x and dy = draw_y − pos_y, computed as unsigned 10-bit modulo 1024. A negative offset therefore becomes large and falls outside the box.
  - Pixel is in the box when dx<SPR_W and dy<SPR_H.
  - col = facing_left ? SPR_W−1−dx : dx.
  - rom_address = {frame_idx, dy[log2 SPR_H−1:0], col[log2 SPR_W−1:0]}.
  - Outside the box: rom_address=0 and sprite_on=0.
- A sprite placed near the right or bottom screen edge is simply clipped. No wrap-around to the opposite edge.

## Timing
- rom_address and sprite_on are registered: valid 1 cycle after draw_x/draw_y. The ROM then reads on the following negedge, and pixel colour is registered on the next posedge. The downstream mux delays sprite_on by 1 cycle to match.
- frame_idx, state and attack_busy update on the posedge where frame_start=1 and are visible the next cycle.
- attack_req to attack_busy takes 1 cycle plus the wait to the next frame_start.
- Attack duration is exactly FRAMES·HOLD frame_start pulses (24 by default).
- Async reset mid-attack immediately returns to IDLE, frame 0, not busy, and discards the pending request.

## Structure
- Package kyo_anim_pkg holds:
  - anim_state_t enum {IDLE, WALK_FWD, WALK_BACK, ATTACK};
  - move code constants MV_IDLE, MV_FWD, MV_BACK;
  - default SPR_W, SPR_H, FRAMES, HOLD.
- Sub-module kyo_anim_seq contains the state machine, hold counter, frame counter and attack handshake.
- The box test, mirroring and address register stay in kyo_anim_ctrl.

## Test plan
- Reset, then move_req=01 with 30 frame_start pulses → frame_idx sequence 0×6, 1×6, 2×6, 3×6, 0×6.
- move_req=10 from IDLE → frame_idx=3 after the first frame_start, 2 after 6 more pulses; after 0 it wraps to 3.
- attack_req pulse mid-frame while walking → attack_busy=1 after the next frame_start. It stays high for 24 pulses, ignores move_req changes, and a second attack_req during the attack is dropped.
- pos=(100,50), frame_idx=2, facing_left=0, draw=(105,60) → rom_address=0x4285 and sprite_on=1 one cycle later. With facing_left=1 → 0x42BA.
- Edge cases:
  - draw=(99,60) → sprite_on=0, rom_address=0.
  - pos_x=600, draw_x=639 → dx=39, in box.
  - pos_x=5, draw_x=2 → dx=1021, out of box.
- Assert reset_n low during ATTACK frame 2 → all outputs 0 asynchronously. After release, IDLE with no stale pending attack.
